// File: rtl/alu_cmd_ctrl.sv
// Issues one ALU command, captures the result, and streams it LSB byte first on a valid/ready TX port.
// Accept-to-first-byte is 3 cycles; TX_READY low freezes the current byte, and commands wait until IDLE.
module alu_cmd_ctrl #(
    parameter int OPER_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int NUM_BYTES  = OUT_WIDTH / 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    input  logic [OPER_WIDTH-1:0] CMD_A,
    input  logic [OPER_WIDTH-1:0] CMD_B,
    input  logic [3:0]            CMD_FUN,
    output logic                  CMD_READY,
    output logic [OPER_WIDTH-1:0] ALU_A,
    output logic [OPER_WIDTH-1:0] ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_VALID,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_READY,
    output logic                  BUSY,
    output logic                  ERR_TIMEOUT
);

    localparam int               IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SEND} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [OUT_WIDTH-1:0]   result_q;
    logic [IDX_W-1:0]       byte_idx;
    logic [IDX_W-1:0]       idx_nxt;
    logic [7:0]             to_cnt;
    logic [7:0]             nxt_byte;
    logic                   tx_fire;
    logic                   last_byte;
    logic                   timed_out;

    assign idx_nxt   = byte_idx + IDX_W'(1);
    assign nxt_byte  = 8'(result_q >> (8 * idx_nxt));
    assign tx_fire   = TX_D_VLD & TX_READY;
    assign last_byte = (byte_idx == LAST_IDX);
    assign timed_out = (to_cnt == TO_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (CMD_VALID) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (OUT_VALID) begin
                    state_nxt = SEND;
                end else if (timed_out) begin
                    state_nxt = IDLE;
                end
            end
            SEND:  if (tx_fire && last_byte) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);

    // Registered outputs and datapath; everything not written in a branch holds its value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ALU_A       <= '0;
            ALU_B       <= '0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            result_q    <= '0;
            byte_idx    <= '0;
            to_cnt      <= '0;
        end else begin
            ALU_EN      <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        ALU_A   <= CMD_A;
                        ALU_B   <= CMD_B;
                        ALU_FUN <= CMD_FUN;
                        ALU_EN  <= 1'b1;
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                end
                WAIT: begin
                    if (OUT_VALID) begin
                        result_q  <= ALU_OUT;
                        byte_idx  <= '0;
                        TX_P_DATA <= ALU_OUT[7:0];
                        TX_D_VLD  <= 1'b1;
                    end else if (timed_out) begin
                        ERR_TIMEOUT <= 1'b1;
                    end else if (to_cnt != 8'hFF) begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                SEND: begin
                    if (tx_fire) begin
                        if (last_byte) begin
                            TX_D_VLD <= 1'b0;
                        end else begin
                            byte_idx  <= idx_nxt;
                            TX_P_DATA <= nxt_byte;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a one-cycle registered ALU stand-in.
module tb_alu_cmd_ctrl;

    logic        CLK;
    logic        RST;
    logic        CMD_VALID;
    logic [7:0]  CMD_A;
    logic [7:0]  CMD_B;
    logic [3:0]  CMD_FUN;
    logic        CMD_READY;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_READY;
    logic        BUSY;
    logic        ERR_TIMEOUT;

    int checks   = 0;
    int failures = 0;

    logic        alu_vld_q;
    logic [15:0] alu_res_q;
    logic        suppress;
    logic        stray;
    logic [15:0] stray_val;
    logic        saw_vld;
    logic        saw_err;

    alu_cmd_ctrl #(
        .OPER_WIDTH(8),
        .OUT_WIDTH (16),
        .TIMEOUT   (15)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CMD_VALID  (CMD_VALID),
        .CMD_A      (CMD_A),
        .CMD_B      (CMD_B),
        .CMD_FUN    (CMD_FUN),
        .CMD_READY  (CMD_READY),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_FUN    (ALU_FUN),
        .ALU_EN     (ALU_EN),
        .ALU_OUT    (ALU_OUT),
        .OUT_VALID  (OUT_VALID),
        .TX_P_DATA  (TX_P_DATA),
        .TX_D_VLD   (TX_D_VLD),
        .TX_READY   (TX_READY),
        .BUSY       (BUSY),
        .ERR_TIMEOUT(ERR_TIMEOUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Registered ALU stand-in: result and valid appear the cycle after ALU_EN is sampled.
    always @(posedge CLK) begin
        if (RST) begin
            alu_vld_q <= 1'b0;
            alu_res_q <= '0;
        end else begin
            alu_vld_q <= ALU_EN;
            if (ALU_EN) begin
                case (ALU_FUN)
                    4'b0000: alu_res_q <= {8'h00, ALU_A} + {8'h00, ALU_B};
                    4'b0001: alu_res_q <= {8'h00, ALU_A} - {8'h00, ALU_B};
                    4'b0010: alu_res_q <= ALU_A * ALU_B;
                    4'b1011: alu_res_q <= (ALU_A < ALU_B) ? 16'd3 : 16'd0;
                    default: alu_res_q <= '0;
                endcase
            end
        end
    end

    assign OUT_VALID = (alu_vld_q & ~suppress) | stray;
    assign ALU_OUT   = stray ? stray_val : alu_res_q;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Caller is at the negedge of cycle 0; returns at the negedge of cycle 5.
    task automatic run_add(input string tag);
        CMD_A = 8'h0F; CMD_B = 8'hF3; CMD_FUN = 4'b0000; CMD_VALID = 1'b1; TX_READY = 1'b1;
        step();
        chk({tag, "_en_c1"}, {15'd0, ALU_EN}, 16'd1);
        chk({tag, "_busy_c1"}, {15'd0, BUSY}, 16'd1);
        chk({tag, "_rdy_c1"}, {15'd0, CMD_READY}, 16'd0);
        chk({tag, "_alu_ab"}, {ALU_A, ALU_B}, 16'h0FF3);
        CMD_VALID = 1'b0;
        step();
        chk({tag, "_en_c2"}, {15'd0, ALU_EN}, 16'd0);
        chk({tag, "_vld_c2"}, {15'd0, TX_D_VLD}, 16'd0);
        step();
        chk({tag, "_b0"}, {7'd0, TX_D_VLD, TX_P_DATA}, 16'h0102);
        step();
        chk({tag, "_b1"}, {7'd0, TX_D_VLD, TX_P_DATA}, 16'h0101);
        step();
        chk({tag, "_vld_c5"}, {15'd0, TX_D_VLD}, 16'd0);
        chk({tag, "_busy_c5"}, {15'd0, BUSY}, 16'd0);
        chk({tag, "_rdy_c5"}, {15'd0, CMD_READY}, 16'd1);
    endtask

    initial begin
        RST = 1'b1; CMD_VALID = 1'b0; CMD_A = '0; CMD_B = '0; CMD_FUN = '0;
        TX_READY = 1'b0; suppress = 1'b0; stray = 1'b0; stray_val = '0;
        step();
        step();
        chk("rst_rdy_busy", {14'd0, CMD_READY, BUSY}, 16'h0002);
        chk("rst_alu", {ALU_A, ALU_B}, 16'h0000);
        chk("rst_en_fun", {11'd0, ALU_EN, ALU_FUN}, 16'h0000);
        chk("rst_tx", {6'd0, ERR_TIMEOUT, TX_D_VLD, TX_P_DATA}, 16'h0000);
        RST = 1'b0;
        step();

        // Basic ADD, full cycle accounting.
        run_add("add");

        // MUL with TX backpressure: 0xFF*0xFF = 0xFE01.
        CMD_A = 8'hFF; CMD_B = 8'hFF; CMD_FUN = 4'b0010; CMD_VALID = 1'b1; TX_READY = 1'b0;
        step();
        CMD_VALID = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            chk("mul_stall", {7'd0, TX_D_VLD, TX_P_DATA}, 16'h0101);
            step();
        end
        chk("mul_b0_rel", {7'd0, TX_D_VLD, TX_P_DATA}, 16'h0101);
        TX_READY = 1'b1;
        step();
        chk("mul_b1", {7'd0, TX_D_VLD, TX_P_DATA}, 16'h01FE);
        step();
        chk("mul_done", {14'd0, TX_D_VLD, CMD_READY}, 16'h0001);

        // Timeout: OUT_VALID suppressed, abort pulse 15 cycles after entering WAIT.
        suppress = 1'b1; saw_vld = 1'b0; saw_err = 1'b0;
        CMD_A = 8'h01; CMD_B = 8'h01; CMD_FUN = 4'b0000; CMD_VALID = 1'b1;
        step();
        CMD_VALID = 1'b0;
        for (int c = 2; c <= 16; c++) begin
            step();
            saw_vld = saw_vld | TX_D_VLD;
            saw_err = saw_err | ERR_TIMEOUT;
        end
        chk("to_early", {15'd0, saw_err}, 16'd0);
        chk("to_busy_c16", {15'd0, BUSY}, 16'd1);
        step();
        chk("to_pulse", {15'd0, ERR_TIMEOUT}, 16'd1);
        chk("to_rdy", {14'd0, CMD_READY, BUSY}, 16'h0002);
        saw_vld = saw_vld | TX_D_VLD;
        step();
        chk("to_pulse_end", {15'd0, ERR_TIMEOUT}, 16'd0);
        saw_vld = saw_vld | TX_D_VLD;
        chk("to_no_tx", {15'd0, saw_vld}, 16'd0);
        suppress = 1'b0;

        // Back-to-back: CMD_VALID stays high across both commands.
        CMD_A = 8'h05; CMD_B = 8'h07; CMD_FUN = 4'b0001; CMD_VALID = 1'b1; TX_READY = 1'b1;
        step();
        chk("b2b_en1", {15'd0, ALU_EN}, 16'd1);
        CMD_A = 8'h01; CMD_B = 8'h02; CMD_FUN = 4'b1011;
        step();
        step();
        chk("b2b_b0", {7'd0, TX_D_VLD, TX_P_DATA}, 16'h01FE);
        step();
        chk("b2b_b1", {7'd0, TX_D_VLD, TX_P_DATA}, 16'h01FF);
        chk("b2b_rdy_last", {15'd0, CMD_READY}, 16'd0);
        step();
        chk("b2b_idle", {13'd0, CMD_READY, ALU_EN, TX_D_VLD}, 16'h0004);
        chk("b2b_a_hold", {ALU_A, 4'd0, ALU_FUN}, 16'h0501);
        step();
        CMD_VALID = 1'b0;
        chk("b2b_en2", {7'd0, ALU_EN, ALU_A}, 16'h0101);
        step();
        step();
        chk("b2b_b2", {7'd0, TX_D_VLD, TX_P_DATA}, 16'h0103);
        step();
        chk("b2b_b3", {7'd0, TX_D_VLD, TX_P_DATA}, 16'h0100);
        step();
        chk("b2b_done", {14'd0, TX_D_VLD, CMD_READY}, 16'h0001);

        // Reset mid-SEND after the first byte transfers.
        CMD_A = 8'h0F; CMD_B = 8'hF3; CMD_FUN = 4'b0000; CMD_VALID = 1'b1; TX_READY = 1'b1;
        step();
        CMD_VALID = 1'b0;
        step();
        step();
        chk("rms_b0", {7'd0, TX_D_VLD, TX_P_DATA}, 16'h0102);
        step();
        RST = 1'b1; TX_READY = 1'b0;
        step();
        RST = 1'b0;
        chk("rms_tx", {6'd0, ERR_TIMEOUT, TX_D_VLD, TX_P_DATA}, 16'h0000);
        chk("rms_alu", {ALU_A, ALU_B}, 16'h0000);
        chk("rms_ctl", {10'd0, CMD_READY, BUSY, ALU_FUN}, 16'h0020);
        chk("rms_en", {15'd0, ALU_EN}, 16'd0);
        step();
        chk("rms_quiet", {14'd0, TX_D_VLD, BUSY}, 16'h0000);
        run_add("rms_add");

        // Stray OUT_VALID in IDLE.
        stray = 1'b1; stray_val = 16'hDEAD;
        step();
        stray = 1'b0;
        chk("stray_idle", {13'd0, CMD_READY, BUSY, TX_D_VLD}, 16'h0004);
        step();
        chk("stray_idle2", {14'd0, BUSY, TX_D_VLD}, 16'h0000);

        // Stray OUT_VALID in SEND while the first byte is stalled.
        CMD_A = 8'h0F; CMD_B = 8'hF3; CMD_FUN = 4'b0000; CMD_VALID = 1'b1; TX_READY = 1'b0;
        step();
        CMD_VALID = 1'b0;
        step();
        step();
        chk("stray_send_b0", {7'd0, TX_D_VLD, TX_P_DATA}, 16'h0102);
        stray = 1'b1; stray_val = 16'hDEAD;
        step();
        stray = 1'b0;
        chk("stray_send_hold", {7'd0, TX_D_VLD, TX_P_DATA}, 16'h0102);
        TX_READY = 1'b1;
        step();
        chk("stray_send_b1", {7'd0, TX_D_VLD, TX_P_DATA}, 16'h0101);
        step();
        chk("stray_send_done", {14'd0, TX_D_VLD, CMD_READY}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
